// File: rtl/cdc_bus_arbiter_pkg.sv
// Shared types and helpers for the cdc_bus_arbiter slice.
//
// Contents:
//   src_state_t : source (clk_in) FSM states.
//   dst_state_t : destination (clk_out) FSM states.
//   id_width(n) : requester-index width, max(1, clog2(n)).
package cdc_arb_pkg;

    typedef enum logic {
        S_IDLE,
        S_WAIT_ACK
    } src_state_t;

    typedef enum logic {
        D_IDLE,
        D_PRESENT
    } dst_state_t;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_bus_arbiter_if.sv
// Bus interface between the requesters, the cdc_bus_arbiter and the
// clk_out-domain consumer.
//
// Signals:
//   req_valid [N_REQ]        per-requester valid (clk_in)
//   req_data  [N_REQ*DATA_W] requester i at [i*DATA_W +: DATA_W] (clk_in)
//   req_ready [N_REQ]        one-hot acceptance pulse (clk_in)
//   busy                     source FSM not idle (clk_in)
//   out_valid                word available (clk_out)
//   out_ready                consumer accepts (clk_out)
//   out_data  [DATA_W]       delivered word (clk_out)
//   out_id    [ID_W]         requester index of the word (clk_out)
//
// Modports: master = requesters + consumer side, slave = arbiter side.
interface cdc_bus_arbiter_if
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    import cdc_arb_pkg::*;

    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [ID_W-1:0]         out_id;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, busy, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, busy, out_valid, out_data, out_id
    );

endinterface

// File: rtl/cdc_bus_arbiter_sync.sv
// cdc_toggle_sync: single-bit multi-flop synchronizer for a toggle signal.
//
// Ports:
//   clk : destination-domain clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : toggle from the foreign domain
//   q   : synchronized toggle (N_STAGE destination edges of latency)
module cdc_toggle_sync
#(
    parameter int N_STAGE = 2
)
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    import cdc_arb_pkg::*;

    // Stage 0 is the metastability-catching flop; keep all stages together.
    (* ASYNC_REG = "TRUE" *) logic [N_STAGE-1:0] sync_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[N_STAGE-2:0], d};
        end
    end

    assign q = sync_p[N_STAGE-1];

endmodule

// File: rtl/cdc_bus_arbiter.sv
// cdc_bus_arbiter: shares one toggle-handshake clock-domain crossing between
// N_REQ clk_in-domain requesters and delivers each word, tagged with its
// requester id, to one consumer in the clk_out domain.
//
// Ports:
//   clk_in  : source / arbiter clock
//   clk_out : destination clock
//   rst     : asynchronous active-high reset for both domains
//   bus     : cdc_bus_arbiter_if.slave (request side in clk_in,
//             delivery side in clk_out)
//
// Build option: define CDC_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no pointer register). Default is round-robin.
//
// Only the req/ack toggles are synchronized. hold_data/hold_id change solely
// at a grant, and the destination reads them only after the matching toggle
// has passed its synchronizer, so the data bus is quasi-static at sampling.
module cdc_bus_arbiter
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int N_STAGE = 2
)
(
    input  logic             clk_in,
    input  logic             clk_out,
    input  logic             rst,
    cdc_bus_arbiter_if.slave bus
);
    import cdc_arb_pkg::*;

    localparam int ID_W = id_width(N_REQ);

    // ------------------------------------------------------------------
    // clk_in domain: grant selection
    // ------------------------------------------------------------------
    src_state_t        src_state;
    logic [N_REQ-1:0]  req_ready_q;
    logic              busy_q;
    logic              req_tgl;
    logic              ack_sync;
    logic [DATA_W-1:0] hold_data;
    logic [ID_W-1:0]   hold_id;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_idx;

`ifdef CDC_ARB_FIXED_PRIO_EN
    // Walk from the top so the lowest set index is the last one written.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
    end
`else
    localparam logic [ID_W:0] N_REQ_W = (ID_W + 1)'(N_REQ);

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   cand;

    // Candidates are ptr+1 .. ptr+N_REQ (mod N_REQ). Walking k downward makes
    // the nearest set requester after the pointer the final assignment.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = {1'b0, ptr} + (ID_W + 1)'(k);
            if (cand >= N_REQ_W) begin
                cand = cand - N_REQ_W;
            end
            if (bus.req_valid[cand[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // clk_in domain: source FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            src_state   <= S_IDLE;
            req_ready_q <= '0;
            busy_q      <= 1'b0;
            req_tgl     <= 1'b0;
`ifndef CDC_ARB_FIXED_PRIO_EN
            ptr         <= ID_W'(N_REQ - 1);
`endif
        end else begin
            case (src_state)
                S_IDLE: begin
                    req_ready_q <= '0;
                    if (gnt_any) begin
                        req_ready_q <= N_REQ'(1) << gnt_idx;
                        req_tgl     <= ~req_tgl;
                        busy_q      <= 1'b1;
`ifndef CDC_ARB_FIXED_PRIO_EN
                        ptr         <= gnt_idx;
`endif
                        src_state   <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    req_ready_q <= '0;
                    // The destination echoes the toggle once the word is taken.
                    if (ack_sync == req_tgl) begin
                        busy_q    <= 1'b0;
                        src_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Payload hold registers: loaded only at a grant, frozen in S_WAIT_ACK.
    always_ff @(posedge clk_in) begin
        if (src_state == S_IDLE && gnt_any) begin
            hold_data <= bus.req_data[gnt_idx * DATA_W +: DATA_W];
            hold_id   <= gnt_idx;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;

    // ------------------------------------------------------------------
    // Toggle crossings
    // ------------------------------------------------------------------
    logic req_sync;
    logic ack_tgl;

    cdc_toggle_sync #(.N_STAGE(N_STAGE)) u_req_sync (
        .clk (clk_out),
        .rst (rst),
        .d   (req_tgl),
        .q   (req_sync)
    );

    cdc_toggle_sync #(.N_STAGE(N_STAGE)) u_ack_sync (
        .clk (clk_in),
        .rst (rst),
        .d   (ack_tgl),
        .q   (ack_sync)
    );

    // ------------------------------------------------------------------
    // clk_out domain: destination FSM
    // ------------------------------------------------------------------
    dst_state_t        dst_state;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ID_W-1:0]   out_id_q;

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            dst_state   <= D_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ack_tgl     <= 1'b0;
        end else begin
            case (dst_state)
                D_IDLE: begin
                    // A toggle mismatch means a new word is parked in hold_*.
                    if (req_sync != ack_tgl) begin
                        out_data_q  <= hold_data;
                        out_id_q    <= hold_id;
                        out_valid_q <= 1'b1;
                        dst_state   <= D_PRESENT;
                    end
                end
                D_PRESENT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        ack_tgl     <= req_sync;
                        dst_state   <= D_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_cdc_bus_arbiter.sv
// Testbench for cdc_bus_arbiter: table of single transfers with hand-derived
// grant ids, plus sequences for backpressure, reset mid-transfer, continuous
// streaming and a scoreboard over several clock ratios.
module tb_cdc_bus_arbiter;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 32;
    localparam int N_STAGE = 2;

    logic clk_in  = 1'b0;
    logic clk_out = 1'b0;
    logic rst     = 1'b1;
    int   half_out = 13;

    always #5 clk_in = ~clk_in;
    always begin
        #(half_out) clk_out = ~clk_out;
    end

    cdc_bus_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    cdc_bus_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .N_STAGE(N_STAGE)) dut (
        .clk_in  (clk_in),
        .clk_out (clk_out),
        .rst     (rst),
        .bus     (bus)
    );

    int checks = 0;
    int passes = 0;
    int grant_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Every acceptance pulse must be one-hot.
    always @(negedge clk_in) begin
        if (!rst && bus.req_ready != '0) begin
            grant_cnt++;
            checks++;
            if ($onehot(bus.req_ready)) passes++;
            else $display("FAIL ready_onehot: got %b expected one-hot", bus.req_ready);
        end
    end

    task automatic do_reset();
        @(negedge clk_in);
        bus.req_valid = '0;
        rst = 1'b1;
        #40;
        rst = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk_in);
        while ((bus.busy || bus.out_valid) && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        chk({name, "_idle"}, {bus.busy, bus.out_valid}, 2'b00);
    endtask

    task automatic do_xfer(input string name, input logic [3:0] mask,
                           input logic [31:0] d [4], input int exp_id,
                           input logic [31:0] exp_data);
        int n;
        @(negedge clk_in);
        for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = d[i];
        bus.req_valid = mask;
        n = 0;
        while (bus.req_ready == '0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk({name, "_ready"}, bus.req_ready, 4'(1) << exp_id);
        bus.req_valid = '0;
        @(negedge clk_in);
        chk({name, "_pulse"}, bus.req_ready, 0);
        n = 0;
        @(negedge clk_out);
        while (!bus.out_valid && n < 200) begin
            @(negedge clk_out);
            n++;
        end
        chk({name, "_id"}, bus.out_id, exp_id);
        chk({name, "_data"}, bus.out_data, exp_data);
        n = 0;
        @(negedge clk_in);
        while (bus.busy && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk({name, "_busy"}, bus.busy, 0);
    endtask

    // Hold mask continuously (data 0x10+i) and check the next n delivered ids.
    task automatic stream(input string name, input logic [3:0] mask, input int exp_ids [6]);
        int got = 0;
        int n = 0;
        @(negedge clk_in);
        for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = 32'h10 + i;
        bus.req_valid = mask;
        while (got < 6 && n < 4000) begin
            @(negedge clk_out);
            n++;
            if (bus.out_valid) begin
                chk($sformatf("%s_id%0d", name, got), bus.out_id, exp_ids[got]);
                chk($sformatf("%s_data%0d", name, got), bus.out_data, 32'h10 + exp_ids[got]);
                got++;
            end
        end
        chk({name, "_count"}, got, 6);
        @(negedge clk_in);
        bus.req_valid = '0;
        wait_idle(name);
    endtask

    typedef struct {
        logic [3:0] mask;
        int         exp_rr;
        int         exp_fp;
    } vec_t;

    vec_t vecs [12];
    logic [35:0] sb_q [$];

    initial begin
        logic [31:0] d [4];
        int exp_id;
        int n;
        int bad;
        int g0;
        int stream_all [6];
        int stream_odd [6];
        int halves [4];
        int delivered;
        int granted;
        bit prod_done;

        vecs[0]  = '{4'b0001, 0, 0};
        vecs[1]  = '{4'b0001, 0, 0};
        vecs[2]  = '{4'b1010, 1, 1};
        vecs[3]  = '{4'b1010, 3, 1};
        vecs[4]  = '{4'b1111, 0, 0};
        vecs[5]  = '{4'b1100, 2, 2};
        vecs[6]  = '{4'b0110, 1, 1};
        vecs[7]  = '{4'b1001, 3, 0};
        vecs[8]  = '{4'b1001, 0, 0};
        vecs[9]  = '{4'b1000, 3, 3};
        vecs[10] = '{4'b0111, 0, 0};
        vecs[11] = '{4'b1111, 1, 0};
`ifdef CDC_ARB_FIXED_PRIO_EN
        stream_all = '{0, 0, 0, 0, 0, 0};
        stream_odd = '{1, 1, 1, 1, 1, 1};
`else
        stream_all = '{0, 1, 2, 3, 0, 1};
        stream_odd = '{1, 3, 1, 3, 1, 3};
`endif
        halves = '{2, 5, 9, 15};

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (4) @(negedge clk_in);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_id", bus.out_id, 0);
        @(negedge clk_in);
        rst = 1'b0;
        repeat (2) @(negedge clk_in);

        // Single word
        d = '{32'hDEADBEEF, 32'h1, 32'h2, 32'h3};
        do_xfer("single", 4'b0001, d, 0, 32'hDEADBEEF);

        // Table of single transfers
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < 4; i++) d[i] = 32'hC0DE0000 + v * 256 + i;
`ifdef CDC_ARB_FIXED_PRIO_EN
            exp_id = vecs[v].exp_fp;
`else
            exp_id = vecs[v].exp_rr;
`endif
            do_xfer($sformatf("vec%0d", v), vecs[v].mask, d, exp_id,
                    32'hC0DE0000 + v * 256 + exp_id);
        end

        // Backpressure
        bus.out_ready = 1'b0;
        @(negedge clk_in);
        bus.req_data[2*32 +: 32] = 32'hB00B0002;
        bus.req_data[0*32 +: 32] = 32'hB00B0000;
        bus.req_valid = 4'b0100;
        n = 0;
        while (bus.req_ready == '0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk("bp_ready2", bus.req_ready, 4'b0100);
        bus.req_valid = 4'b0001;
        n = 0;
        @(negedge clk_out);
        while (!bus.out_valid && n < 200) begin
            @(negedge clk_out);
            n++;
        end
        chk("bp_first_data", bus.out_data, 32'hB00B0002);
        chk("bp_first_id", bus.out_id, 2);
        g0 = grant_cnt;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_out);
            if (!bus.out_valid || bus.out_data != 32'hB00B0002 || bus.out_id != 2 || !bus.busy)
                bad++;
        end
        chk("bp_held_cycles_bad", bad, 0);
        chk("bp_no_grant", grant_cnt, g0);
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.out_valid && n < 200) begin
            @(negedge clk_out);
            n++;
        end
        chk("bp_release", bus.out_valid, 0);
        n = 0;
        @(negedge clk_in);
        while (bus.req_ready == '0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk("bp_ready0", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        n = 0;
        @(negedge clk_out);
        while (!bus.out_valid && n < 200) begin
            @(negedge clk_out);
            n++;
        end
        chk("bp_second_data", bus.out_data, 32'hB00B0000);
        chk("bp_second_id", bus.out_id, 0);
        wait_idle("bp");

        // Reset while waiting for the ack
        bus.out_ready = 1'b0;
        @(negedge clk_in);
        bus.req_data[1*32 +: 32] = 32'h5A5A0001;
        bus.req_valid = 4'b0010;
        n = 0;
        while (bus.req_ready == '0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        bus.req_valid = '0;
        repeat (3) @(negedge clk_in);
        chk("mid_busy_before", bus.busy, 1);
        rst = 1'b1;
        #40;
        rst = 1'b0;
        @(negedge clk_in);
        chk("mid_busy_after", bus.busy, 0);
        @(negedge clk_out);
        chk("mid_out_valid_after", bus.out_valid, 0);
        chk("mid_out_data_after", bus.out_data, 0);
        bus.out_ready = 1'b1;
        d = '{32'h0, 32'h600D0001, 32'h0, 32'h0};
        do_xfer("mid_next", 4'b0010, d, 1, 32'h600D0001);

        // Continuous streaming from a fresh pointer
        do_reset();
        stream("all4", 4'b1111, stream_all);
        do_reset();
        stream("odd", 4'b1010, stream_odd);

        // Scoreboard over several clock ratios
        for (int h = 0; h < 4; h++) begin
            half_out = halves[h];
            do_reset();
            sb_q.delete();
            delivered = 0;
            granted = 0;
            prod_done = 1'b0;
            fork
                begin
                    for (int cyc = 0; cyc < 300; cyc++) begin
                        @(negedge clk_in);
                        for (int i = 0; i < 4; i++) begin
                            if (bus.req_valid[i] && bus.req_ready[i]) begin
                                sb_q.push_back({4'(i), bus.req_data[i*32 +: 32]});
                                granted++;
                                bus.req_valid[i] = 1'b0;
                            end
                        end
                        if (cyc < 299) begin
                            for (int i = 0; i < 4; i++) begin
                                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                                    bus.req_data[i*32 +: 32] = $urandom;
                                    bus.req_valid[i] = 1'b1;
                                end
                            end
                        end else begin
                            bus.req_valid = '0;
                        end
                    end
                    prod_done = 1'b1;
                end
                begin
                    logic [35:0] e;
                    int t = 0;
                    while (!(prod_done && sb_q.size() == 0 && !bus.busy) && t < 40000) begin
                        @(negedge clk_out);
                        t++;
                        bus.out_ready = ($urandom_range(0, 2) != 0);
                        if (bus.out_valid && bus.out_ready) begin
                            delivered++;
                            if (sb_q.size() == 0) begin
                                chk($sformatf("sb%0d_unexpected", h), 1, 0);
                            end else begin
                                e = sb_q.pop_front();
                                chk($sformatf("sb%0d_id", h), bus.out_id, e[35:32]);
                                chk($sformatf("sb%0d_data", h), bus.out_data, e[31:0]);
                            end
                        end
                    end
                    chk($sformatf("sb%0d_drain", h), sb_q.size(), 0);
                end
            join
            bus.out_ready = 1'b1;
            chk($sformatf("sb%0d_count", h), delivered, granted);
            chk($sformatf("sb%0d_activity", h), (granted > 5), 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
